// File: rtl/range_counter_multi_pkg.sv
// Shared constants for the programmable range counter: mode encodings and
// bounce-direction values.
package range_counter_pkg;
   localparam logic [1:0] MODE_WRAP   = 2'b00;
   localparam logic [1:0] MODE_SAT    = 2'b01;
   localparam logic [1:0] MODE_BOUNCE = 2'b10;

   localparam logic DIR_UP = 1'b1;
   localparam logic DIR_DN = 1'b0;
endpackage

// File: rtl/range_counter_multi_range_next.sv
// Next-state logic for the range counter: range recovery plus wrap,
// saturate and bounce stepping, evaluated at WIDTH+1 bits so nothing overflows.
module range_next
   import range_counter_pkg::*;
#(
   parameter int WIDTH = 6
) (
   input  logic [WIDTH-1:0] count,
   input  logic             dir,
   input  logic [WIDTH-1:0] s,
   input  logic [WIDTH-1:0] lo,
   input  logic [WIDTH-1:0] hi,
   input  logic [1:0]       mode,
   input  logic             up,
   output logic [WIDTH-1:0] next_count,
   output logic             next_dir,
   output logic             evt_next
);
   logic [WIDTH:0] sum;
   logic [WIDTH:0] diff;
   logic           borrow;
   logic           eff_up;

   assign sum    = {1'b0, count} + {1'b0, s};
   assign diff   = {1'b0, count} - {1'b0, s};
   assign borrow = diff[WIDTH];
   assign eff_up = (mode == MODE_BOUNCE) ? dir : up;

   always_comb begin
      next_count = count;
      next_dir   = dir;
      evt_next   = 1'b0;
      // Out-of-window counts snap to the bound we are heading away from.
      if (count < lo || count > hi) begin
         next_count = eff_up ? lo : hi;
      end else begin
         case (mode)
            MODE_SAT: begin
               if (eff_up) begin
                  if (sum >= {1'b0, hi}) begin
                     next_count = hi;
                     evt_next   = (count != hi);
                  end else begin
                     next_count = sum[WIDTH-1:0];
                  end
               end else if (borrow || diff[WIDTH-1:0] <= lo) begin
                  next_count = lo;
                  evt_next   = (count != lo);
               end else begin
                  next_count = diff[WIDTH-1:0];
               end
            end
            MODE_BOUNCE: begin
               if (eff_up) begin
                  if (sum >= {1'b0, hi}) begin
                     next_count = hi;
                     next_dir   = DIR_DN;
                     evt_next   = 1'b1;
                  end else begin
                     next_count = sum[WIDTH-1:0];
                  end
               end else if (borrow || diff[WIDTH-1:0] <= lo) begin
                  next_count = lo;
                  next_dir   = DIR_UP;
                  evt_next   = 1'b1;
               end else begin
                  next_count = diff[WIDTH-1:0];
               end
            end
            default: begin
               if (eff_up) begin
                  if (sum > {1'b0, hi}) begin
                     next_count = lo;
                     evt_next   = 1'b1;
                  end else begin
                     next_count = sum[WIDTH-1:0];
                  end
               end else if (borrow || diff[WIDTH-1:0] < lo) begin
                  next_count = hi;
                  evt_next   = 1'b1;
               end else begin
                  next_count = diff[WIDTH-1:0];
               end
            end
         endcase
      end
   end
endmodule

// File: rtl/range_counter_multi.sv
// Bounded counter over a run-time window [lo, hi] with programmable step and
// wrap/saturate/bounce modes; holds the count, bounce direction and event registers.
module range_counter_multi
   import range_counter_pkg::*;
#(
   parameter int WIDTH   = 6,
   parameter bit DEF_DIR = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             up,
   input  logic [1:0]       mode,
   input  logic [WIDTH-1:0] step,
   input  logic [WIDTH-1:0] lo,
   input  logic [WIDTH-1:0] hi,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] count,
   output logic             evt,
   output logic             at_lo,
   output logic             at_hi,
   output logic             cfg_err
);
   logic             dir;
   logic [WIDTH-1:0] s;
   logic [WIDTH-1:0] next_count;
   logic             next_dir;
   logic             evt_next;

   assign s       = (step == '0) ? WIDTH'(1) : step;
   assign cfg_err = (lo > hi);
   assign at_lo   = (count == lo);
   assign at_hi   = (count == hi);

   range_next #(.WIDTH(WIDTH)) u_next (
      .count      (count),
      .dir        (dir),
      .s          (s),
      .lo         (lo),
      .hi         (hi),
      .mode       (mode),
      .up         (up),
      .next_count (next_count),
      .next_dir   (next_dir),
      .evt_next   (evt_next)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
         evt   <= 1'b0;
         dir   <= DEF_DIR;
      end else if (load) begin
         count <= load_val;
         evt   <= 1'b0;
      end else if (cfg_err) begin
         count <= lo;
         evt   <= 1'b0;
      end else if (en) begin
         count <= next_count;
         dir   <= next_dir;
         evt   <= evt_next;
      end else begin
         evt   <= 1'b0;
      end
   end
endmodule

// File: tb/tb_range_counter_multi.sv
// Table-driven bench for range_counter_multi: vectors carry their own expected
// count/evt, expectations are queued on drive and popped after the clock edge.
module tb_range_counter_multi;
   logic       clk = 1'b0;
   logic       rst;
   logic       en;
   logic       up;
   logic [1:0] mode;
   logic [5:0] step;
   logic [5:0] lo;
   logic [5:0] hi;
   logic       load;
   logic [5:0] load_val;
   logic [5:0] count;
   logic       evt;
   logic       at_lo;
   logic       at_hi;
   logic       cfg_err;

   typedef struct {
      logic       en;
      logic       up;
      logic [1:0] mode;
      logic [5:0] step;
      logic [5:0] lo;
      logic [5:0] hi;
      logic       load;
      logic [5:0] load_val;
      logic [5:0] exp_count;
      logic       exp_evt;
   } vec_t;

   typedef struct {
      int         id;
      logic [9:0] v;
   } exp_t;

   vec_t vecs[$];
   exp_t sb[$];
   int   n_vec = 0;
   int   n_bad = 0;
   int   split;

   range_counter_multi #(.WIDTH(6), .DEF_DIR(1'b1)) dut (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .up       (up),
      .mode     (mode),
      .step     (step),
      .lo       (lo),
      .hi       (hi),
      .load     (load),
      .load_val (load_val),
      .count    (count),
      .evt      (evt),
      .at_lo    (at_lo),
      .at_hi    (at_hi),
      .cfg_err  (cfg_err)
   );

   always #5 clk = ~clk;

   // Packed observation: {count, evt, at_lo, at_hi, cfg_err}
   function automatic logic [9:0] observed();
      return {count, evt, at_lo, at_hi, cfg_err};
   endfunction

   task automatic check(input string name, input logic [9:0] act, input logic [9:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got count=%0d evt=%b at_lo=%b at_hi=%b cfg_err=%b, want count=%0d evt=%b at_lo=%b at_hi=%b cfg_err=%b",
                  name, act[9:4], act[3], act[2], act[1], act[0],
                  exp[9:4], exp[3], exp[2], exp[1], exp[0]);
      end
   endtask

   task automatic add(input logic e, input logic u, input logic [1:0] m, input logic [5:0] st,
                      input logic [5:0] l, input logic [5:0] h, input logic ld,
                      input logic [5:0] lv, input logic [5:0] ec, input logic ee);
      vec_t v;
      v.en = e; v.up = u; v.mode = m; v.step = st; v.lo = l; v.hi = h;
      v.load = ld; v.load_val = lv; v.exp_count = ec; v.exp_evt = ee;
      vecs.push_back(v);
   endtask

   task automatic apply(input vec_t v, input int id);
      exp_t e;
      exp_t got;
      en = v.en; up = v.up; mode = v.mode; step = v.step;
      lo = v.lo; hi = v.hi; load = v.load; load_val = v.load_val;
      e.id = id;
      e.v  = {v.exp_count, v.exp_evt, v.exp_count == v.lo, v.exp_count == v.hi, v.lo > v.hi};
      sb.push_back(e);
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
         n_vec++;
         n_bad++;
         $display("FAIL vec%0d: scoreboard empty", id);
      end else begin
         got = sb.pop_front();
         check($sformatf("vec%0d", got.id), observed(), got.v);
      end
   endtask

   initial begin
      // Wrap up 10..40 step 1 from reset: first enabled cycle recovers to 10.
      for (int i = 10; i <= 40; i++) add(1, 1, 2'b00, 1, 10, 40, 0, 0, 6'(i), 0);
      add(1, 1, 2'b00, 1, 10, 40, 0, 0, 10, 1);
      // Wrap down step 7 from 12.
      add(1, 0, 2'b00, 7, 10, 40, 1, 12, 12, 0);
      add(1, 0, 2'b00, 7, 10, 40, 0, 0, 40, 1);
      add(1, 0, 2'b00, 7, 10, 40, 0, 0, 33, 0);
      add(1, 0, 2'b00, 7, 10, 40, 0, 0, 26, 0);
      add(1, 0, 2'b00, 7, 10, 40, 0, 0, 19, 0);
      add(1, 0, 2'b00, 7, 10, 40, 0, 0, 12, 0);
      add(1, 0, 2'b00, 7, 10, 40, 0, 0, 40, 1);
      // Saturate up then down.
      add(1, 1, 2'b01, 5, 0, 20, 1, 17, 17, 0);
      add(1, 1, 2'b01, 5, 0, 20, 0, 0, 20, 1);
      add(1, 1, 2'b01, 5, 0, 20, 0, 0, 20, 0);
      add(1, 1, 2'b01, 5, 0, 20, 0, 0, 20, 0);
      add(1, 0, 2'b01, 5, 0, 20, 1, 7, 7, 0);
      add(1, 0, 2'b01, 5, 0, 20, 0, 0, 2, 0);
      add(1, 0, 2'b01, 5, 0, 20, 0, 0, 0, 1);
      add(1, 0, 2'b01, 5, 0, 20, 0, 0, 0, 0);
      // Bounce 10..12; up input deliberately 0 since bounce ignores it.
      add(1, 0, 2'b10, 1, 10, 12, 1, 10, 10, 0);
      add(1, 0, 2'b10, 1, 10, 12, 0, 0, 11, 0);
      add(1, 0, 2'b10, 1, 10, 12, 0, 0, 12, 1);
      add(1, 0, 2'b10, 1, 10, 12, 0, 0, 11, 0);
      add(1, 0, 2'b10, 1, 10, 12, 0, 0, 10, 1);
      add(1, 0, 2'b10, 1, 10, 12, 0, 0, 11, 0);
      add(1, 0, 2'b10, 1, 10, 12, 0, 0, 12, 1);
      // Load beats enable, then out-of-range recovery, then hold.
      add(1, 1, 2'b00, 1, 10, 40, 1, 63, 63, 0);
      add(1, 1, 2'b00, 1, 10, 40, 0, 0, 10, 0);
      add(0, 1, 2'b00, 1, 10, 40, 0, 0, 10, 0);
      // step 0 acts as 1; evt clears when enable drops.
      add(1, 1, 2'b00, 0, 10, 40, 1, 38, 38, 0);
      add(1, 1, 2'b00, 0, 10, 40, 0, 0, 39, 0);
      add(1, 1, 2'b00, 0, 10, 40, 0, 0, 40, 0);
      add(1, 1, 2'b00, 0, 10, 40, 0, 0, 10, 1);
      add(0, 1, 2'b00, 0, 10, 40, 0, 0, 10, 0);
      // Full-width window with a step that overflows 6 bits both ways.
      add(1, 1, 2'b00, 63, 0, 63, 1, 1, 1, 0);
      add(1, 1, 2'b00, 63, 0, 63, 0, 0, 0, 1);
      add(1, 0, 2'b00, 63, 0, 63, 0, 0, 63, 1);
      // lo == hi: saturate silent, wrap fires every enabled cycle.
      add(1, 1, 2'b01, 1, 5, 5, 1, 5, 5, 0);
      add(1, 1, 2'b01, 1, 5, 5, 0, 0, 5, 0);
      add(1, 1, 2'b00, 1, 5, 5, 0, 0, 5, 1);
      add(1, 1, 2'b00, 1, 5, 5, 0, 0, 5, 1);
      add(1, 0, 2'b00, 1, 5, 5, 0, 0, 5, 1);
      split = vecs.size();
      // cfg_err forces lo regardless of enable.
      add(0, 1, 2'b00, 1, 30, 20, 0, 0, 30, 0);
      add(1, 1, 2'b00, 1, 30, 20, 0, 0, 30, 0);
      // Bounce after reset: direction must be back to DEF_DIR (up).
      add(1, 0, 2'b10, 0, 10, 12, 0, 0, 10, 0);
      add(1, 0, 2'b10, 0, 10, 12, 0, 0, 11, 0);
      add(1, 0, 2'b10, 0, 10, 12, 0, 0, 12, 1);

      rst = 1'b1; en = 1'b0; up = 1'b1; mode = 2'b00; step = 6'd1;
      lo = 6'd10; hi = 6'd40; load = 1'b0; load_val = 6'd0;
      #1;
      check("reset_state", observed(), {6'd0, 1'b0, 1'b0, 1'b0, 1'b0});
      @(posedge clk);
      #1;
      check("reset_hold", observed(), {6'd0, 1'b0, 1'b0, 1'b0, 1'b0});
      rst = 1'b0;

      for (int i = 0; i < split; i++) apply(vecs[i], i);

      // Asynchronous reset mid-cycle, after a cycle that left evt=1 and count=5.
      #2;
      rst = 1'b1;
      #1;
      check("async_rst", observed(), {6'd0, 1'b0, 1'b0, 1'b0, 1'b0});
      en = 1'b0;
      @(posedge clk);
      #1;
      check("async_rst_hold", observed(), {6'd0, 1'b0, 1'b0, 1'b0, 1'b0});
      rst = 1'b0;

      lo = 6'd30; hi = 6'd20;
      #1;
      check("cfg_err_comb", observed(), {6'd0, 1'b0, 1'b0, 1'b0, 1'b1});

      for (int i = split; i < vecs.size(); i++) apply(vecs[i], i);

      if (sb.size() != 0) begin
         n_vec++;
         n_bad++;
         $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
